ring_router: RTL

- Per-node ring router stage directly downstream of the traffic-generating node.
- Accepts the node's 8-bit packets into an injection FIFO. Forwards transit traffic from the previous ring hop to the next hop. Ejects packets addressed to this node.
- Packet format: [3:0] src, [7:4] dest.
- Ring direction is ascending address (node k feeds node (k+1) mod NUM_NODES).

---
 rtl/ring_pkg.sv | 32 +++
 rtl/ring_inj_fifo.sv | 52 +++++
 rtl/ring_router.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ring_pkg.sv
// Shared packet layout and helpers for the ring router.
// A packet is {dest, src}, with 4 bits per field.
package ring_pkg;

   localparam int unsigned ADDR_W   = 4;
   localparam int unsigned PKT_W    = 8;
   localparam int unsigned SRC_LSB  = 0;
   localparam int unsigned DEST_LSB = 4;

   typedef enum logic [1:0] {
      ClsPass,
      ClsLocal,
      ClsOrphan
   } tclass_e;

   function automatic logic [ADDR_W-1:0] pkt_src(input logic [PKT_W-1:0] pkt);
      return pkt[SRC_LSB +: ADDR_W];
   endfunction

   function automatic logic [ADDR_W-1:0] pkt_dest(input logic [PKT_W-1:0] pkt);
      return pkt[DEST_LSB +: ADDR_W];
   endfunction

   // An orphan is a packet this node sent that has come all the way around the ring.
   function automatic tclass_e pkt_classify(input logic [PKT_W-1:0]  pkt,
                                            input logic [ADDR_W-1:0] node);
      if (pkt_dest(pkt) == node) return ClsLocal;
      if (pkt_src(pkt) == node)  return ClsOrphan;
      return ClsPass;
   endfunction

endpackage

// File: rtl/ring_inj_fifo.sv
// Synchronous injection FIFO with a registered occupancy count.
// The full and empty flags are derived from that count.
module ring_inj_fifo
   import ring_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [PKT_W-1:0] wdata,
   input  logic             pop,
   output logic [PKT_W-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [PKT_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wptr_q, rptr_q;
   logic [PTR_W:0]   cnt_q;
   logic             do_push, do_pop;

   assign full    = (cnt_q == (PTR_W+1)'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem_q[rptr_q];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wptr_q] <= wdata;
            wptr_q        <= wptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rptr_q <= rptr_q + PTR_W'(1);
         end
         if (do_push && !do_pop) begin
            cnt_q <= cnt_q + (PTR_W+1)'(1);
         end else if (!do_push && do_pop) begin
            cnt_q <= cnt_q - (PTR_W+1)'(1);
         end
      end
   end

endmodule

// File: rtl/ring_router.sv
// Per-node ring router: forwards transit traffic, ejects local packets,
// and injects node traffic from a FIFO, with a starvation guard on ring_out.
module ring_router
   import ring_pkg::*;
#(
   parameter int unsigned NUM_NODES    = 16,
   parameter int unsigned INJ_DEPTH    = 4,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] node_addr,
   input  logic              inj_valid,
   input  logic [PKT_W-1:0]  inj_packet,
   output logic              inj_ready,
   input  logic              ring_in_valid,
   input  logic [PKT_W-1:0]  ring_in_packet,
   output logic              ring_in_ready,
   output logic              ring_out_valid,
   output logic [PKT_W-1:0]  ring_out_packet,
   input  logic              ring_out_ready,
   output logic              eject_valid,
   output logic [PKT_W-1:0]  eject_packet,
   input  logic              eject_ready,
   output logic [7:0]        drop_cnt
);

   localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

   logic [PKT_W-1:0]    fifo_head;
   logic                fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic                ro_valid_q, ro_valid_d, ej_valid_q, ej_valid_d;
   logic [PKT_W-1:0]    ro_pkt_q, ro_pkt_d, ej_pkt_q, ej_pkt_d;
   logic [STARVE_W-1:0] starve_q, starve_d;
   logic [7:0]          drop_q, drop_d;
   logic [8:0]          drop_sum;
   tclass_e             tin_cls;
   logic                head_valid, head_loop, forced, ro_free, ej_free;
   logic                pass_win, inj_grant, local_win, loop_grant;
   logic                dest_ok, inj_drop, orphan_drop;

   ring_inj_fifo #(
      .DEPTH (INJ_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .wdata (inj_packet),
      .pop   (fifo_pop),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      tin_cls    = pkt_classify(ring_in_packet, node_addr);
      head_valid = !fifo_empty;
      head_loop  = (pkt_dest(fifo_head) == node_addr);
      ro_free    = !ro_valid_q || ring_out_ready;
      ej_free    = !ej_valid_q || eject_ready;
      forced     = head_valid && !head_loop && (starve_q == STARVE_W'(STARVE_LIMIT));

      // Readiness depends only on class and slot state, never on ring_in_valid.
      unique case (tin_cls)
         ClsLocal:  ring_in_ready = ej_free;
         ClsOrphan: ring_in_ready = 1'b1;
         ClsPass:   ring_in_ready = ro_free && !forced;
         default:   ring_in_ready = 1'b0;
      endcase

      pass_win    = ring_in_valid && (tin_cls == ClsPass) && ro_free && !forced;
      inj_grant   = ro_free && head_valid && !head_loop && !pass_win;
      local_win   = ring_in_valid && (tin_cls == ClsLocal) && ej_free;
      loop_grant  = ej_free && head_valid && head_loop && !local_win;
      fifo_pop    = inj_grant || loop_grant;

      inj_ready   = !fifo_full;
      dest_ok     = (32'(pkt_dest(inj_packet)) < NUM_NODES);
      fifo_push   = inj_valid && inj_ready && dest_ok;
      inj_drop    = inj_valid && inj_ready && !dest_ok;
      orphan_drop = ring_in_valid && (tin_cls == ClsOrphan);

      ro_valid_d = ro_valid_q && !ring_out_ready;
      ro_pkt_d   = ro_pkt_q;
      if (pass_win) begin
         ro_valid_d = 1'b1;
         ro_pkt_d   = ring_in_packet;
      end else if (inj_grant) begin
         ro_valid_d = 1'b1;
         ro_pkt_d   = fifo_head;
      end

      ej_valid_d = ej_valid_q && !eject_ready;
      ej_pkt_d   = ej_pkt_q;
      if (local_win) begin
         ej_valid_d = 1'b1;
         ej_pkt_d   = ring_in_packet;
      end else if (loop_grant) begin
         ej_valid_d = 1'b1;
         ej_pkt_d   = fifo_head;
      end

      // pass_win implies !forced, so the count cannot pass STARVE_LIMIT.
      starve_d = starve_q;
      if (!head_valid || fifo_pop) begin
         starve_d = '0;
      end else if (!head_loop && pass_win) begin
         starve_d = starve_q + STARVE_W'(1);
      end

      drop_sum = {1'b0, drop_q} + 9'(inj_drop) + 9'(orphan_drop);
      drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ro_valid_q <= 1'b0;
         ro_pkt_q   <= '0;
         ej_valid_q <= 1'b0;
         ej_pkt_q   <= '0;
         starve_q   <= '0;
         drop_q     <= '0;
      end else begin
         ro_valid_q <= ro_valid_d;
         ro_pkt_q   <= ro_pkt_d;
         ej_valid_q <= ej_valid_d;
         ej_pkt_q   <= ej_pkt_d;
         starve_q   <= starve_d;
         drop_q     <= drop_d;
      end
   end

   assign ring_out_valid  = ro_valid_q;
   assign ring_out_packet = ro_pkt_q;
   assign eject_valid     = ej_valid_q;
   assign eject_packet    = ej_pkt_q;
   assign drop_cnt        = drop_q;

endmodule
